// File: rtl/mem_copy_dma.sv
// ============================================================================
//  Module      : mem_copy_dma
//  Description : Byte-serial forward memory copy engine (READ/WRITE per byte)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_copy_dma (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining,
    output logic       aborted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_src_ptr;
    logic [7:0] r_dst_ptr;
    logic [7:0] r_count;
    logic [7:0] r_buf;
    logic       r_aborted;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_src_ptr <= 8'h00;
            r_dst_ptr <= 8'h00;
            r_count   <= 8'h00;
            r_buf     <= 8'h00;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src_ptr <= src_addr;
                        r_dst_ptr <= dst_addr;
                        r_count   <= length;
                        r_aborted <= 1'b0;
                    end
                end
                ST_READ: begin
                    r_buf <= mem_rdata;
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The write in this cycle commits even when aborting
                    r_src_ptr <= r_src_ptr + 8'd1;
                    r_dst_ptr <= r_dst_ptr + 8'd1;
                    r_count   <= r_count - 8'd1;
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                default: begin
                    r_aborted <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == 8'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = abort ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = (abort || (r_count == 8'd1)) ? ST_DONE : ST_READ;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them without a clock
    always_comb begin
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        remaining = 8'h00;
        aborted   = 1'b0;
        case (r_state)
            ST_READ: begin
                mem_addr  = r_src_ptr;
                busy      = 1'b1;
                remaining = r_count;
            end
            ST_WRITE: begin
                mem_addr  = r_dst_ptr;
                mem_wdata = r_buf;
                mem_we    = 1'b1;
                busy      = 1'b1;
                remaining = r_count;
            end
            ST_DONE: begin
                done      = 1'b1;
                remaining = r_count;
                aborted   = r_aborted;
            end
            default: begin
                mem_addr  = 8'h00;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
// ============================================================================
//  Module      : tb_mem_copy_dma
//  Description : Directed, table-driven bench for mem_copy_dma with memory model
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_copy_dma;

    localparam int   C_BUDGET = 600;
    localparam logic [7:0] C_BG = 8'hEE;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       start;
    logic       abort;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic       aborted;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        int          n_init;
        logic [31:0] init;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    mem_copy_dma dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .aborted   (aborted)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; commits img into memory at the next posedge
    task automatic load_mem();
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic fill_img(input logic [7:0] base, input int n, input logic [31:0] bytes);
        logic [7:0] a;
        for (int i = 0; i < 256; i++) img[i] = C_BG;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            img[a] = bytes[8*i +: 8];
        end
    endtask

    // Called at a negedge; k counts negedges after the accepting edge
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            output int lat, output int bc, output int wc,
                            output int ab, output int rem);
        int k;
        bit got;
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        k = 0; got = 0; lat = -1; bc = 0; wc = 0; ab = -1; rem = -1;
        while (!got && k < C_BUDGET) begin
            @(negedge CLK);
            k++;
            if (busy)   bc++;
            if (mem_we) wc++;
            if (done) begin
                got = 1; lat = k; ab = int'(aborted); rem = int'(remaining);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        int lat, bc, wc, ab, rem, k, wcount;
        bit got;
        logic [7:0] a;

        vecs[0] = '{src: 8'h10, dst: 8'h40, len: 8'd3, n_init: 3, init: 32'h00C3B2A1, exp: 32'h00C3B2A1};
        vecs[1] = '{src: 8'hFE, dst: 8'h80, len: 8'd4, n_init: 4, init: 32'h04030201, exp: 32'h04030201};
        vecs[2] = '{src: 8'h30, dst: 8'h50, len: 8'd0, n_init: 0, init: 32'h0,        exp: 32'h0};
        vecs[3] = '{src: 8'h20, dst: 8'h21, len: 8'd4, n_init: 1, init: 32'h00000055, exp: 32'h55555555};
        vecs[4] = '{src: 8'h00, dst: 8'hFF, len: 8'd1, n_init: 1, init: 32'h0000007E, exp: 32'h0000007E};

        RST_N = 1'b0; start = 1'b0; abort = 1'b0; load = 1'b0;
        src_addr = 8'h0; dst_addr = 8'h0; length = 8'h0;
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_aborted", int'(aborted), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill_img(vecs[v].src, vecs[v].n_init, vecs[v].init);
            load_mem();
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, lat, bc, wc, ab, rem);
            check($sformatf("v%0d_latency", v), lat, 2 * int'(vecs[v].len) + 1);
            check($sformatf("v%0d_busy_cycles", v), bc, 2 * int'(vecs[v].len));
            check($sformatf("v%0d_writes", v), wc, int'(vecs[v].len));
            check($sformatf("v%0d_aborted", v), ab, 0);
            check($sformatf("v%0d_remaining", v), rem, 0);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].dst + 8'(i);
                check($sformatf("v%0d_dst%0d", v, i), int'(mem[a]), int'(vecs[v].exp[8*i +: 8]));
            end
            @(negedge CLK);
            check($sformatf("v%0d_idle_done", v), int'(done), 0);
        end

        // Abort during the 3rd WRITE of a 10-byte copy
        fill_img(8'h60, 4, 32'h04030201);
        load_mem();
        src_addr = 8'h60; dst_addr = 8'hA0; length = 8'd10; start = 1'b1;
        k = 0; wcount = 0; got = 0;
        while (!got && k < C_BUDGET) begin
            @(negedge CLK);
            k++;
            start = 1'b0;
            if (mem_we) wcount++;
            abort = (mem_we && wcount == 3);
            if (done) begin
                got = 1;
                check("abort_latency", k, 7);
                check("abort_flag", int'(aborted), 1);
                check("abort_remaining", int'(remaining), 7);
            end
        end
        abort = 1'b0;
        check("abort_writes", wcount, 3);
        check("abort_dst0", int'(mem[8'hA0]), 8'h01);
        check("abort_dst2", int'(mem[8'hA2]), 8'h03);
        check("abort_dst3_untouched", int'(mem[8'hA3]), int'(C_BG));
        @(negedge CLK);
        check("abort_done_one_cycle", int'(done), 0);
        check("abort_flag_one_cycle", int'(aborted), 0);

        // Start held high while busy and through DONE
        for (int i = 0; i < 256; i++) img[i] = C_BG;
        img[8'h70] = 8'h11; img[8'h71] = 8'h22; img[8'h90] = 8'h99;
        load_mem();
        src_addr = 8'h70; dst_addr = 8'h48; length = 8'd2; start = 1'b1;
        k = 0; got = 0;
        while (!got && k < C_BUDGET) begin
            @(negedge CLK);
            k++;
            src_addr = 8'h90; dst_addr = 8'h4C; length = 8'd1;
            if (done) got = 1;
        end
        check("busy_start_latency", k, 5);
        check("busy_start_dst0", int'(mem[8'h48]), 8'h11);
        check("busy_start_dst1", int'(mem[8'h49]), 8'h22);
        @(negedge CLK);
        check("held_start_idle_busy", int'(busy), 0);
        @(negedge CLK);
        check("held_start_accepted", int'(busy), 1);
        start = 1'b0;
        k = 0; got = 0;
        while (!got && k < C_BUDGET) begin
            @(negedge CLK);
            k++;
            if (done) got = 1;
        end
        check("held_start_latency", k, 2);
        check("held_start_dst", int'(mem[8'h4C]), 8'h99);
        @(negedge CLK);

        // Asynchronous reset during the 4th WRITE
        fill_img(8'hC0, 4, 32'h33323130);
        load_mem();
        src_addr = 8'hC0; dst_addr = 8'hD0; length = 8'd10; start = 1'b1;
        k = 0; wcount = 0;
        while (wcount < 4 && k < C_BUDGET) begin
            @(negedge CLK);
            k++;
            start = 1'b0;
            if (mem_we) wcount++;
        end
        check("rstmid_reached_write4", wcount, 4);
        #2;
        RST_N = 1'b0;
        #1;
        check("rstmid_we", int'(mem_we), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_rem", int'(remaining), 0);
        got = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (done) got = 1;
        end
        check("rstmid_no_done", int'(got), 0);
        check("rstmid_dst2_kept", int'(mem[8'hD2]), 8'h32);
        check("rstmid_dst3_unwritten", int'(mem[8'hD3]), int'(C_BG));
        RST_N = 1'b1;
        run_copy(8'hC0, 8'hE0, 8'd2, lat, bc, wc, ab, rem);
        check("after_rst_latency", lat, 5);
        check("after_rst_dst0", int'(mem[8'hE0]), 8'h30);
        check("after_rst_dst1", int'(mem[8'hE1]), 8'h31);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RST_N.
REQ-002 CLK  input  1  rising-edge clock shared with the data memory.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 start  input  1  copy request, sampled only in IDLE.
REQ-005 abort  input  1  terminate the active copy early.
REQ-006 src_addr  input  8  first source byte address, latched on an accepted start.
REQ-007 dst_addr  input  8  first destination byte address, latched on an accepted start.
REQ-008 length  input  8  byte count 0..255, latched on an accepted start.
REQ-009 mem_rdata  input  8  combinational read data returned by the data memory for mem_addr.
REQ-010 mem_addr  output  8  data memory address.
REQ-011 mem_wdata  output  8  data memory write data.
REQ-012 mem_we  output  1  data memory write enable; the memory commits mem_wdata on the rising edge.
REQ-013 busy  output  1  high in READ and WRITE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 remaining  output  8  bytes not yet written.
REQ-016 aborted  output  1  high together with done when the copy ended through abort; otherwise 0.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and DONE, with registered state, pointers, count and buffer.
REQ-018 IDLE: when start=1 at the edge, latch src_ptr, dst_ptr and count.
  - Go to READ if length!=0; go to DONE if length==0.
REQ-019 READ: mem_addr=src_ptr and mem_we=0.
  - At the edge, capture mem_rdata into an 8-bit buffer and go to WRITE.
REQ-020 WRITE: mem_addr=dst_ptr, mem_wdata=buffer and mem_we=1.
  - At the edge, src_ptr+1, dst_ptr+1 and count-1.
  - Go to DONE if count was 1; otherwise go to READ.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-022 mem_we SHALL be 1 only in WRITE; in IDLE and DONE, mem_addr=0, mem_wdata=0 and mem_we=0.
REQ-023 Pointers SHALL increment modulo 256, so 8'hFF is followed by 8'h00 with no error flag.
REQ-024 Copying SHALL be strictly forward, byte by byte.
  - With overlapping regions, each read returns memory contents as of that cycle, including bytes already written by this copy.
REQ-025 Latency: after a start accepted at edge E0, done SHALL be high in the cycle after edge E0+2*length.
  - For length=0, that is the cycle after E0, with no memory access.
REQ-026 start SHALL be ignored outside IDLE, including in the DONE cycle.
  - A start held high through DONE is accepted in the following IDLE cycle.
REQ-027 abort=1 at an edge in READ SHALL go to DONE with no further write.
REQ-028 abort=1 at an edge in WRITE SHALL go to DONE.
  - The write asserted in that cycle still commits; pointers and count update for it.
REQ-029 abort SHALL be ignored in IDLE and DONE; abort and start high together in IDLE SHALL accept start.
REQ-030 remaining SHALL equal count in READ, WRITE and DONE, and 0 in IDLE.
REQ-031 In READ and WRITE, busy SHALL be 1 and done SHALL be 0.

Reset
REQ-032 RST_N=0 SHALL immediately force state=IDLE and clear all outputs, pointers, count, buffer and aborted.
REQ-033 The clear of REQ-032 SHALL be asynchronous, independent of CLK.
REQ-034 Reset asserted mid-copy SHALL deassert mem_we immediately.
  - No done pulse follows; destination bytes already written remain.
REQ-035 After RST_N rises, the first start SHALL be accepted at the next rising edge.

Verification
REQ-036 Basic copy: mem[0x10..0x12]=0xA1,0xB2,0xC3; start with src=0x10, dst=0x40, len=3.
  - Required: mem[0x40..0x42]=0xA1,0xB2,0xC3; done high 7 cycles after the start edge; busy high for 6 cycles; aborted=0.
REQ-037 Wrap: src=0xFE, dst=0x80, len=4, mem[0xFE,0xFF,0x00,0x01]=1,2,3,4.
  - Required: mem[0x80..0x83]=1,2,3,4.
REQ-038 Zero length: start with len=0.
  - Required: done in the next cycle, mem_we never asserted, busy never asserted.
REQ-039 Overlap: mem[0x20]=0x55; start with src=0x20, dst=0x21, len=4.
  - Required: mem[0x21..0x24] all 0x55.
REQ-040 Abort: len=10, abort pulsed during the 3rd WRITE.
  - Required: exactly 3 bytes written; done=1 and aborted=1 for one cycle; remaining=7 in that cycle.
REQ-041 Reset and start while busy:
  - Start asserted while busy: required to be ignored.
  - RST_N low mid-copy, asynchronous to CLK: required busy=0 and mem_we=0 before the next edge, no done pulse, and a fresh start completes normally.
